add_accum_lanes: RTL and testbench

- Multi-lane successor of the PE addition stage, sitting between the multiply stage and output-activation write-back.
- Each lane does the following:
  - Truncates a double-width signed product by a run-time shift, with optional round-half-up.
  - Adds the truncated value to the output activation.
  - Registers the result for write-back.
- New behaviour:
  - Per-lane saturation.
  - Load and clear modes.
  - Write-back-to-add forwarding, which hides the register-file read-after-write hazard for back-to-back updates of the same address.
  - Sticky overflow status with an event counter.

---
 rtl/add_accum_lanes.sv | 147 ++++++++++++++
 tb/tb_add_accum_lanes.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_accum_lanes.sv
`default_nettype none
// ============================================================================
// Module : add_accum_lanes
// Brief  : Multi-lane truncate/round, saturating accumulate and write-back stage
// Rev    : 1.0  initial release
// ============================================================================
module add_accum_lanes #(
    parameter int LANES         = 4,
    parameter int PE_DATA_WIDTH = 16,
    parameter int ACT_WIDTH     = 24,
    parameter int ADDR_WIDTH    = 6,
    parameter int TRUNC_WIDTH   = 5,
    parameter int SAT_EN        = 1,
    parameter int ROUND_EN      = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [5:0]                         PE_IDX,
    input  logic [1:0]                         comp_en_add,
    input  logic [LANES*ACT_WIDTH-1:0]         out_act_value_add,
    input  logic [LANES*2*PE_DATA_WIDTH-1:0]   mult_result_add,
    input  logic [TRUNC_WIDTH-1:0]             trunc_amount_add,
    input  logic [ADDR_WIDTH-1:0]              out_act_addr_add,
    input  logic                               ovf_clr,
    output logic                               out_act_write_en,
    output logic [ADDR_WIDTH-1:0]              out_act_addr_wb,
    output logic [LANES*ACT_WIDTH-1:0]         add_result_wb,
    output logic [LANES-1:0]                   ovf_sticky,
    output logic [CNT_WIDTH-1:0]               ovf_count
);

    localparam int         c_PROD_W     = 2 * PE_DATA_WIDTH;
    localparam int         c_EXT_W      = c_PROD_W + 1;
    localparam int         c_EV_W       = $clog2(LANES + 1);
    localparam logic [1:0] c_MODE_IDLE  = 2'b00;
    localparam logic [1:0] c_MODE_ACC   = 2'b01;
    localparam logic [1:0] c_MODE_LOAD  = 2'b10;
    localparam logic [1:0] c_MODE_CLEAR = 2'b11;

    logic                       out_act_write_en_q, out_act_write_en_d;
    logic [ADDR_WIDTH-1:0]      out_act_addr_wb_q,  out_act_addr_wb_d;
    logic [LANES*ACT_WIDTH-1:0] add_result_wb_q,    add_result_wb_d;
    logic [LANES-1:0]           ovf_sticky_q,       ovf_sticky_d;
    logic [CNT_WIDTH-1:0]       ovf_count_q,        ovf_count_d;

    logic                       w_active;
    logic                       w_fwd;
    logic [LANES-1:0]           w_lane_ovf;
    logic [c_EV_W-1:0]          w_events;
    logic [CNT_WIDTH-1:0]       w_cnt_base;
    logic [CNT_WIDTH:0]         w_cnt_sum;

    assign w_active = (comp_en_add != c_MODE_IDLE);
    // The register file has not yet seen last cycle's write; take it from the wb stage.
    assign w_fwd    = out_act_write_en_q && (out_act_addr_wb_q == out_act_addr_add);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [c_EXT_W-1:0]              w_rnd;
            logic signed [c_EXT_W-1:0]       w_rounded;
            logic signed [PE_DATA_WIDTH-1:0] w_t_narrow;
            logic [ACT_WIDTH-1:0]            w_t;
            logic [ACT_WIDTH-1:0]            w_opa;
            logic [ACT_WIDTH-1:0]            w_sum;
            logic [ACT_WIDTH-1:0]            w_res;
            logic                            w_ovf;

            always_comb begin
                w_rnd = '0;
                if (ROUND_EN != 0 && trunc_amount_add != '0)
                    w_rnd = (c_EXT_W'(1) << trunc_amount_add) >> 1;
                // One guard bit keeps the rounding add from overflowing.
                w_rounded  = {mult_result_add[gi*c_PROD_W + c_PROD_W - 1],
                              mult_result_add[gi*c_PROD_W +: c_PROD_W]} + w_rnd;
                w_t_narrow = PE_DATA_WIDTH'(w_rounded >>> trunc_amount_add);
                w_t        = ACT_WIDTH'(w_t_narrow);
                w_opa      = w_fwd ? add_result_wb_q[gi*ACT_WIDTH +: ACT_WIDTH]
                                   : out_act_value_add[gi*ACT_WIDTH +: ACT_WIDTH];
                w_sum      = w_opa + w_t;
                w_ovf      = (comp_en_add == c_MODE_ACC) &&
                             (w_opa[ACT_WIDTH-1] == w_t[ACT_WIDTH-1]) &&
                             (w_sum[ACT_WIDTH-1] != w_opa[ACT_WIDTH-1]);
                w_res      = add_result_wb_q[gi*ACT_WIDTH +: ACT_WIDTH];
                case (comp_en_add)
                    c_MODE_ACC: begin
                        if (w_ovf && SAT_EN != 0)
                            w_res = {w_opa[ACT_WIDTH-1], {(ACT_WIDTH-1){~w_opa[ACT_WIDTH-1]}}};
                        else
                            w_res = w_sum;
                    end
                    c_MODE_LOAD:  w_res = w_t;
                    c_MODE_CLEAR: w_res = '0;
                    default:      ;
                endcase
            end

            assign add_result_wb_d[gi*ACT_WIDTH +: ACT_WIDTH] = w_res;
            assign w_lane_ovf[gi]                             = w_ovf;
        end
    endgenerate

    always_comb begin
        w_events = '0;
        for (int i = 0; i < LANES; i++)
            w_events = w_events + c_EV_W'(w_lane_ovf[i]);
        // A same-cycle clear drops history but keeps this cycle's events.
        w_cnt_base         = ovf_clr ? '0 : ovf_count_q;
        w_cnt_sum          = {1'b0, w_cnt_base} + (CNT_WIDTH+1)'(w_events);
        ovf_count_d        = w_cnt_sum[CNT_WIDTH] ? '1 : w_cnt_sum[CNT_WIDTH-1:0];
        ovf_sticky_d       = (ovf_clr ? '0 : ovf_sticky_q) | w_lane_ovf;
        out_act_write_en_d = w_active;
        out_act_addr_wb_d  = w_active ? out_act_addr_add : out_act_addr_wb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_act_write_en_q <= 1'b0;
            out_act_addr_wb_q  <= '0;
            add_result_wb_q    <= '0;
            ovf_sticky_q       <= '0;
            ovf_count_q        <= '0;
        end else begin
            out_act_write_en_q <= out_act_write_en_d;
            out_act_addr_wb_q  <= out_act_addr_wb_d;
            add_result_wb_q    <= add_result_wb_d;
            ovf_sticky_q       <= ovf_sticky_d;
            ovf_count_q        <= ovf_count_d;
        end
    end

    assign out_act_write_en = out_act_write_en_q;
    assign out_act_addr_wb  = out_act_addr_wb_q;
    assign add_result_wb    = add_result_wb_q;
    assign ovf_sticky       = ovf_sticky_q;
    assign ovf_count        = ovf_count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (rst_n && w_lane_ovf[i])
                $display("add_accum_lanes warning: PE %0d lane %0d accumulate overflow", PE_IDX, i);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_accum_lanes.sv
`default_nettype none
// ============================================================================
// Module : tb_add_accum_lanes
// Brief  : Scoreboard bench; one saturating/rounding DUT and one wrapping/truncating DUT
// Rev    : 1.0  initial release
// ============================================================================
module tb_add_accum_lanes;

    localparam int L   = 4;
    localparam int PW  = 16;
    localparam int AW  = 24;
    localparam int ADW = 6;
    localparam int TW  = 5;
    localparam int CW  = 16;
    localparam int OW  = 1 + ADW + L*AW + L + CW;
    localparam longint MAXV = 64'sd8388607;
    localparam longint MINV = -64'sd8388608;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [5:0]        pe_idx = 6'd3;
    logic [1:0]        mode  = 2'b00;
    logic [L*AW-1:0]   act   = '0;
    logic [L*2*PW-1:0] prod  = '0;
    logic [TW-1:0]     trunc = '0;
    logic [ADW-1:0]    addr  = '0;
    logic              clr   = 1'b0;

    logic              we_a, we_b;
    logic [ADW-1:0]    wba_a, wba_b;
    logic [L*AW-1:0]   data_a, data_b;
    logic [L-1:0]      sticky_a, sticky_b;
    logic [CW-1:0]     cnt_a, cnt_b;
    logic [OW-1:0]     obs_a, obs_b;

    always #5 clk = ~clk;

    add_accum_lanes #(.SAT_EN(1), .ROUND_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .PE_IDX(pe_idx), .comp_en_add(mode),
        .out_act_value_add(act), .mult_result_add(prod), .trunc_amount_add(trunc),
        .out_act_addr_add(addr), .ovf_clr(clr), .out_act_write_en(we_a),
        .out_act_addr_wb(wba_a), .add_result_wb(data_a), .ovf_sticky(sticky_a),
        .ovf_count(cnt_a));

    add_accum_lanes #(.SAT_EN(0), .ROUND_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .PE_IDX(pe_idx), .comp_en_add(mode),
        .out_act_value_add(act), .mult_result_add(prod), .trunc_amount_add(trunc),
        .out_act_addr_add(addr), .ovf_clr(clr), .out_act_write_en(we_b),
        .out_act_addr_wb(wba_b), .add_result_wb(data_b), .ovf_sticky(sticky_b),
        .ovf_count(cnt_b));

    assign obs_a = {we_a, wba_a, data_a, sticky_a, cnt_a};
    assign obs_b = {we_b, wba_b, data_b, sticky_b, cnt_b};

    int            checks = 0;
    int            errors = 0;
    logic [OW-1:0] sb_a[$];
    logic [OW-1:0] sb_b[$];
    logic [OW-1:0] exp_a, exp_b;

    // Reference state per DUT: index 0 = saturating/rounding, 1 = wrapping/truncating.
    bit            m_we[2];
    logic [ADW-1:0] m_addr[2];
    logic [AW-1:0] m_data[2][L];
    logic [L-1:0]  m_sticky[2];
    int            m_cnt[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_we[d] = 1'b0; m_addr[d] = '0; m_sticky[d] = '0; m_cnt[d] = 0;
            for (int i = 0; i < L; i++) m_data[d][i] = '0;
        end
        sb_a.delete();
        sb_b.delete();
    endtask

    function automatic logic [OW-1:0] pack_exp(input int d);
        logic [L*AW-1:0] dv;
        for (int i = 0; i < L; i++) dv[i*AW +: AW] = m_data[d][i];
        return {m_we[d], m_addr[d], dv, m_sticky[d], CW'(m_cnt[d])};
    endfunction

    task automatic drive(input logic [1:0] md, input logic [L*AW-1:0] a,
                         input logic [L*2*PW-1:0] p, input logic [TW-1:0] tr,
                         input logic [ADW-1:0] ad, input logic c);
        longint opa, pv, t, r;
        bit     fwd, sat, rnd;
        int     ev;
        logic [L-1:0] st;
        @(negedge clk);
        mode = md; act = a; prod = p; trunc = tr; addr = ad; clr = c;
        for (int d = 0; d < 2; d++) begin
            sat = (d == 0);
            rnd = (d == 0);
            fwd = m_we[d] && (m_addr[d] == ad);
            ev  = 0;
            st  = c ? '0 : m_sticky[d];
            for (int i = 0; i < L; i++) begin
                opa = fwd ? longint'($signed(m_data[d][i])) : longint'($signed(a[i*AW +: AW]));
                pv  = longint'($signed(p[i*2*PW +: 2*PW]));
                if (rnd && tr != 0) pv = pv + (longint'(1) << (tr - 1));
                pv  = pv >>> tr;
                t   = longint'($signed(pv[PW-1:0]));
                r   = 0;
                case (md)
                    2'b01: begin
                        r = opa + t;
                        if (r > MAXV || r < MINV) begin
                            ev++;
                            st[i] = 1'b1;
                            if (sat) r = (r > MAXV) ? MAXV : MINV;
                        end
                    end
                    2'b10:   r = t;
                    default: r = 0;
                endcase
                if (md != 2'b00) m_data[d][i] = r[AW-1:0];
            end
            m_sticky[d] = st;
            m_cnt[d]    = (c ? 0 : m_cnt[d]) + ev;
            if (m_cnt[d] > 65535) m_cnt[d] = 65535;
            m_we[d] = (md != 2'b00);
            if (md != 2'b00) m_addr[d] = ad;
        end
        sb_a.push_back(pack_exp(0));
        sb_b.push_back(pack_exp(1));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (obs_a !== '0) begin errors++; $display("FAIL reset_a got=%h exp=0", obs_a); end
        checks++;
        if (obs_b !== '0) begin errors++; $display("FAIL reset_b got=%h exp=0", obs_b); end
        rst_n = 1'b1;
    endtask

    task automatic test_accumulate();
        drive(2'b01, {4{24'd100}},
              {32'h0000_0000, 32'hFFFF_F400, 32'h0000_0C80, 32'h0000_0C00}, 5'd8, 6'd1, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL accum_a got=%h exp=%h", obs_a, exp_a); end
        checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL accum_b got=%h exp=%h", obs_b, exp_b); end
        checks++; if (data_a[AW-1:0] !== 24'd112 || we_a !== 1'b1)
            begin errors++; $display("FAIL accum_lane0 got=%0d we=%b exp=112 we=1", data_a[AW-1:0], we_a); end
        checks++; if (data_a[2*AW-1:AW] !== 24'd113 || data_b[2*AW-1:AW] !== 24'd112)
            begin errors++; $display("FAIL accum_half got=%0d/%0d exp=113/112", data_a[2*AW-1:AW], data_b[2*AW-1:AW]); end
    endtask

    task automatic test_rounding();
        logic [L*2*PW-1:0] p_tab[3];
        logic [TW-1:0]     tr_tab[3];
        p_tab[0]  = {32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FE80, 32'h0000_0180};
        tr_tab[0] = 5'd8;
        p_tab[1]  = {32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_8000, 32'h0001_2345};
        tr_tab[1] = 5'd0;
        p_tab[2]  = {32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        tr_tab[2] = 5'd31;
        for (int k = 0; k < 3; k++) begin
            drive(2'b10, {4{24'd777}}, p_tab[k], tr_tab[k], 6'd2, 1'b0);
            exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL round%0d_a got=%h exp=%h", k, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL round%0d_b got=%h exp=%h", k, obs_b, exp_b); end
            if (k == 0) begin
                checks++; if (data_a[AW-1:0] !== 24'd2 || data_b[AW-1:0] !== 24'd1)
                    begin errors++; $display("FAIL round_pos got=%h/%h exp=2/1", data_a[AW-1:0], data_b[AW-1:0]); end
                checks++; if (data_a[2*AW-1:AW] !== 24'hFFFFFF || data_b[2*AW-1:AW] !== 24'hFFFFFE)
                    begin errors++; $display("FAIL round_neg got=%h/%h exp=ffffff/fffffe", data_a[2*AW-1:AW], data_b[2*AW-1:AW]); end
            end
            if (k == 1) begin
                checks++; if (data_a[AW-1:0] !== 24'h002345 || data_a[2*AW-1:AW] !== 24'hFF8000)
                    begin errors++; $display("FAIL trunc_wrap got=%h/%h exp=002345/ff8000", data_a[AW-1:0], data_a[2*AW-1:AW]); end
            end
        end
    endtask

    task automatic test_forwarding();
        logic [ADW-1:0] ad_tab[5];
        int             fexp[5];
        ad_tab = '{6'd5, 6'd5, 6'd9, 6'd5, 6'd6};
        fexp   = '{7, 14, 7, 7, 7};
        for (int k = 0; k < 5; k++) begin
            drive(2'b01, '0, {4{32'd7}}, 5'd0, ad_tab[k], 1'b0);
            exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL fwd%0d_a got=%h exp=%h", k, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL fwd%0d_b got=%h exp=%h", k, obs_b, exp_b); end
            checks++; if (data_a[AW-1:0] !== AW'(fexp[k]) || data_b[AW-1:0] !== AW'(fexp[k]))
                begin errors++; $display("FAIL fwd%0d_lane0 got=%0d/%0d exp=%0d", k, data_a[AW-1:0], data_b[AW-1:0], fexp[k]); end
        end
    endtask

    task automatic test_saturation();
        drive(2'b01, {24'd0, 24'd0, 24'd0, 24'h7FFFF0}, {96'd0, 32'h0000_0020}, 5'd0, 6'd10, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL sat1_a got=%h exp=%h", obs_a, exp_a); end
        checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL sat1_b got=%h exp=%h", obs_b, exp_b); end
        checks++; if (data_a[AW-1:0] !== 24'h7FFFFF || data_b[AW-1:0] !== 24'h800010)
            begin errors++; $display("FAIL sat_clamp got=%h/%h exp=7fffff/800010", data_a[AW-1:0], data_b[AW-1:0]); end
        checks++; if (cnt_a !== 16'd1 || cnt_b !== 16'd1 || sticky_a !== 4'b0001 || sticky_b !== 4'b0001)
            begin errors++; $display("FAIL sat_status got=%0d/%0d %b/%b exp=1/1 0001", cnt_a, cnt_b, sticky_a, sticky_b); end
        drive(2'b01, {24'd0, 24'h800000, 24'h800000, 24'd0},
              {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0}, 5'd0, 6'd11, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL sat2_a got=%h exp=%h", obs_a, exp_a); end
        checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL sat2_b got=%h exp=%h", obs_b, exp_b); end
        checks++; if (cnt_a !== 16'd3 || sticky_a !== 4'b0111 || data_a[2*AW-1:AW] !== 24'h800000 || data_b[2*AW-1:AW] !== 24'h7FFFFF)
            begin errors++; $display("FAIL sat_two_lanes got=%0d %b %h/%h exp=3 0111 800000/7fffff", cnt_a, sticky_a, data_a[2*AW-1:AW], data_b[2*AW-1:AW]); end
    endtask

    task automatic test_modes();
        drive(2'b10, {4{24'd500}}, {4{32'hFFFF_FFFD}}, 5'd0, 6'd12, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a || data_a !== {4{24'hFFFFFD}})
            begin errors++; $display("FAIL load got=%h exp=%h", obs_a, exp_a); end
        drive(2'b11, {4{24'd500}}, {4{32'd9}}, 5'd0, 6'd13, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a || data_a !== '0 || we_a !== 1'b1)
            begin errors++; $display("FAIL clear got=%h exp=%h", obs_a, exp_a); end
        drive(2'b00, {4{24'd44}}, {4{32'd9}}, 5'd0, 6'd20, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_b !== exp_b || we_b !== 1'b0 || data_b !== '0 || wba_b !== 6'd13)
            begin errors++; $display("FAIL idle got=%h exp=%h", obs_b, exp_b); end
        drive(2'b01, {24'h7FFFFF, 72'd0}, {32'd1, 96'd0}, 5'd0, 6'd14, 1'b1);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a || cnt_a !== 16'd1 || sticky_a !== 4'b1000)
            begin errors++; $display("FAIL clr_event got=%0d %b exp=1 1000", cnt_a, sticky_a); end
        checks++; if (obs_b !== exp_b || cnt_b !== 16'd1)
            begin errors++; $display("FAIL clr_event_b got=%h exp=%h", obs_b, exp_b); end
    endtask

    task automatic test_back_to_back();
        logic [L*AW-1:0]   ra;
        logic [L*2*PW-1:0] rp;
        for (int k = 0; k < 80; k++) begin
            ra = {$urandom(), $urandom(), $urandom()};
            rp = {$urandom(), $urandom(), $urandom(), $urandom()};
            drive(2'($urandom_range(0, 3)), ra, rp, TW'($urandom_range(0, 31)),
                  ADW'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
            exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
            checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL b2b%0d_a got=%h exp=%h", k, obs_a, exp_a); end
            checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL b2b%0d_b got=%h exp=%h", k, obs_b, exp_b); end
        end
    endtask

    task automatic test_async_reset();
        drive(2'b01, {4{24'd1}}, {4{32'd1}}, 5'd0, 6'd30, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a) begin errors++; $display("FAIL pre_rst got=%h exp=%h", obs_a, exp_a); end
        @(negedge clk);
        #2;
        rst_n = 1'b0; mode = 2'b00; clr = 1'b0;
        #1;
        checks++; if (obs_a !== '0 || obs_b !== '0)
            begin errors++; $display("FAIL async_rst got=%h/%h exp=0", obs_a, obs_b); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, {4{24'd3}}, {4{32'd4}}, 5'd0, 6'd7, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_a !== exp_a || we_a !== 1'b0)
            begin errors++; $display("FAIL post_rst_idle got=%h exp=%h", obs_a, exp_a); end
        drive(2'b01, {4{24'd3}}, {4{32'd4}}, 5'd0, 6'd7, 1'b0);
        exp_a = sb_a.pop_front(); exp_b = sb_b.pop_front();
        checks++; if (obs_b !== exp_b) begin errors++; $display("FAIL post_rst_b got=%h exp=%h", obs_b, exp_b); end
        checks++; if (we_a !== 1'b1 || data_a[AW-1:0] !== 24'd7 || wba_a !== 6'd7)
            begin errors++; $display("FAIL post_rst_acc got=%0d we=%b exp=7 we=1", data_a[AW-1:0], we_a); end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_rounding();
        test_forwarding();
        test_saturation();
        test_modes();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
